// File: rtl/riscstrong_pkg.sv
// Shared constants for the fetch path.
package riscstrong_pkg;

    localparam int          XLEN        = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] PC_RESET    = 32'h0;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    // Force a fetch target onto an instruction boundary.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with flush; caller never pushes when full or pops when empty.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;

    assign pop_data_o = mem_q[rd_ptr_q];
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;

    // Occupancy next-state; simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i)
            count_d = count_q + 1'b1;
        else if (pop_i && !push_i)
            count_d = count_q - 1'b1;
    end

    // Pointers and occupancy; flush empties the FIFO in one cycle.
    always_ff @(posedge clk) begin
        if (reset || clr_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_i && !clr_i)
            mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues imem reads at pc_q, buffers responses with their PCs,
// and squashes everything fetched before a redirect.
module fetch_unit
    import riscstrong_pkg::*;
#(
    parameter int XLEN  = riscstrong_pkg::XLEN,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_q,
    output logic [XLEN-1:0] pc_next,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr_data,
    output logic [XLEN-1:0] instr_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     outst_q, outst_d;
    logic [CW-1:0]     drop_q, drop_d;
    logic [CW-1:0]     buf_cnt, tag_cnt;
    logic              buf_empty, tag_empty;
    logic [XLEN-1:0]   tag;
    logic [CW:0]       credit_used;
    logic              fire, rsp_keep, instr_pop;
    logic [2*XLEN-1:0] buf_head;
    logic              sig_unused;

    // Requests in flight plus buffered words may never exceed DEPTH, which
    // keeps both FIFOs from overflowing without any full checks.
    assign credit_used    = {1'b0, outst_q} + {1'b0, buf_cnt};
    assign imem_req_valid = !reset && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign imem_req_addr  = pc_q;
    assign fire           = imem_req_valid && imem_req_ready;

    // A response is kept only when no older redirect is still draining and
    // no redirect is happening right now.
    assign rsp_keep  = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
    assign instr_pop = instr_valid && instr_ready;

    assign instr_valid = !reset && !buf_empty;
    assign instr_pc    = buf_head[2*XLEN-1:XLEN];
    assign instr_data  = buf_head[XLEN-1:0];

    assign sig_unused = ^{tag_cnt, tag_empty, redirect_pc[1:0]};

    // PC of each outstanding request, popped as responses return (kept or dropped).
    sync_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_fifo (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (1'b0),
        .push_i     (fire),
        .push_data_i(pc_q),
        .pop_i      (imem_rsp_valid),
        .pop_data_o (tag),
        .empty_o    (tag_empty),
        .count_o    (tag_cnt)
    );

    // {pc, word} entries waiting for decode; a redirect wipes them.
    sync_fifo #(.WIDTH(2*XLEN), .DEPTH(DEPTH)) u_ibuf (
        .clk        (clk),
        .reset      (reset),
        .clr_i      (redirect_valid),
        .push_i     (rsp_keep),
        .push_data_i({tag, imem_rsp_data}),
        .pop_i      (instr_pop),
        .pop_data_o (buf_head),
        .empty_o    (buf_empty),
        .count_o    (buf_cnt)
    );

    // Next PC back to program_counter; redirect targets are word aligned.
    always_comb begin
        pc_next = pc_q;
        if (reset)
            pc_next = XLEN'(PC_RESET);
        else if (redirect_valid)
            pc_next = align_pc(redirect_pc);
        else if (fire)
            pc_next = pc_q + XLEN'(INSTR_BYTES);
    end

    // Outstanding and drop counters. On redirect every request still in
    // flight after this cycle must be discarded.
    always_comb begin
        outst_d = outst_q;
        case ({fire, imem_rsp_valid})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
        drop_d = drop_q;
        if (redirect_valid)
            drop_d = outst_q - CW'(imem_rsp_valid);
        else if (imem_rsp_valid && (drop_q != '0))
            drop_d = drop_q - 1'b1;
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a program_counter register and a
// queued instruction memory (1-cycle latency, optional hold).
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_q, pc_next;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid, instr_ready;
    logic [31:0] instr_data, instr_pc;

    logic        mem_hold;
    logic [31:0] mem_q[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    fetch_unit #(.XLEN(32), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_q          (pc_q),
        .pc_next       (pc_next),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr (imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr_data    (instr_data),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    // program_counter register
    always @(posedge clk) pc_q <= reset ? 32'h0 : pc_next;

    // instruction memory: queue requests, return oldest one per cycle unless held
    always @(posedge clk) begin
        if (reset) begin
            mem_q.delete();
            imem_rsp_valid <= 1'b0;
            imem_rsp_data  <= 32'h0;
        end else begin
            if (imem_req_valid && imem_req_ready) mem_q.push_back(imem_req_addr);
            if (!mem_hold && mem_q.size() > 0) begin
                imem_rsp_valid <= 1'b1;
                imem_rsp_data  <= mem_q.pop_front() ^ 32'hA5A5_0000;
            end else begin
                imem_rsp_valid <= 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // pc_next rule when neither reset nor redirect is active
    task automatic chk_pcn();
        chk("pc_next_rule", pc_next,
            (imem_req_valid && imem_req_ready) ? pc_q + 32'd4 : pc_q);
    endtask

    task automatic wait_instr(input logic [31:0] pc, input string tag);
        int c = 0;
        while (!instr_valid && c < 20) begin
            chk_pcn();
            tick();
            c++;
        end
        chk({tag, "_valid"}, 32'(instr_valid), 32'd1);
        chk({tag, "_pc"}, instr_pc, pc);
        chk({tag, "_data"}, instr_data, pc ^ 32'hA5A5_0000);
        chk_pcn();
        tick();
    endtask

    task automatic wait_fire(input logic [31:0] addr, input logic [31:0] nxt, input string tag);
        int c = 0;
        while (!(imem_req_valid && imem_req_ready) && c < 20) begin
            tick();
            c++;
        end
        chk({tag, "_fire"}, 32'(imem_req_valid), 32'd1);
        chk({tag, "_addr"}, imem_req_addr, addr);
        chk({tag, "_pcnext"}, pc_next, nxt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        tick();
        tick();
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_pc_next", pc_next, 32'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        int nf;
        logic [31:0] a0, a1;
        reset = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        mem_hold = 1'b0;

        // 1: streaming fetch from 0
        do_reset();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_addr", imem_req_addr, 32'h0);
        chk("t1_pc_next", pc_next, 32'h4);
        chk("t1_no_instr", 32'(instr_valid), 32'd0);
        wait_instr(32'h0, "t1_i0");
        wait_instr(32'h4, "t1_i1");
        wait_instr(32'h8, "t1_i2");
        wait_instr(32'hC, "t1_i3");

        // 2: decode stalls, credits cap requests at two
        instr_ready = 1'b0;
        do_reset();
        nf = 0; a0 = 32'hX; a1 = 32'hX;
        for (int i = 0; i < 10; i++) begin
            if (imem_req_valid && imem_req_ready) begin
                if (nf == 0) a0 = imem_req_addr; else a1 = imem_req_addr;
                nf++;
            end
            tick();
        end
        chk("t2_nfires", 32'(nf), 32'd2);
        chk("t2_addr0", a0, 32'h0);
        chk("t2_addr1", a1, 32'h4);
        chk("t2_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t2_pc_hold", pc_next, 32'h8);
        chk("t2_head_pc", instr_pc, 32'h0);
        instr_ready = 1'b1;
        wait_instr(32'h0, "t2_i0");
        wait_instr(32'h4, "t2_i1");
        wait_instr(32'h8, "t2_i2");

        // 3: redirect with two requests outstanding
        mem_hold = 1'b1;
        do_reset();
        tick();
        tick();
        chk("t3_credit_out", 32'(imem_req_valid), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        #1;
        chk("t3_pc_next", pc_next, 32'h100);
        chk("t3_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        mem_hold = 1'b0;
        #1;
        chk("t3_buf_empty", 32'(instr_valid), 32'd0);
        wait_instr(32'h100, "t3_i0");
        wait_instr(32'h104, "t3_i1");

        // 4: redirect coinciding with a response and a head pop
        do_reset();
        tick();
        tick();
        chk("t4_rsp_here", 32'(imem_rsp_valid), 32'd1);
        chk("t4_head_valid", 32'(instr_valid), 32'd1);
        chk("t4_head_pc", instr_pc, 32'h0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        #1;
        chk("t4_pc_next", pc_next, 32'h200);
        chk("t4_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        wait_instr(32'h200, "t4_i0");
        wait_instr(32'h204, "t4_i1");

        // 5: PC wraps at the top of the address space
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("t5_pc_next", pc_next, 32'hFFFF_FFFC);
        tick();
        redirect_valid = 1'b0;
        #1;
        wait_fire(32'hFFFF_FFFC, 32'h0, "t5");
        wait_instr(32'hFFFF_FFFC, "t5_i0");
        wait_instr(32'h0, "t5_i1");

        // 6: reset mid-operation with the buffer full
        instr_ready = 1'b0;
        do_reset();
        repeat (10) tick();
        chk("t6_full", 32'(instr_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("t6_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("t6_rst_pc_next", pc_next, 32'h0);
        tick();
        reset = 1'b0;
        #1;
        chk("t6_instr_valid", 32'(instr_valid), 32'd0);
        chk("t6_req0_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req0_addr", imem_req_addr, 32'h0);
        chk("t6_pc_next", pc_next, 32'h4);
        tick();
        chk("t6_req1_valid", 32'(imem_req_valid), 32'd1);
        chk("t6_req1_addr", imem_req_addr, 32'h4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
